// File: rtl/s2p_pkg.sv
// Shared types for the serial-to-parallel deserializer.
package s2p_pkg;

    typedef enum logic {FILL, STALL} s2p_state_t;

endpackage

// File: rtl/shift_register.sv
// WIDTH-bit shift register with parallel load; shift direction set by SHIFT_RIGHT.
module shift_register #(
    parameter int WIDTH       = 5,
    parameter int SHIFT_RIGHT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             shift_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end else if (shift) begin
            if (SHIFT_RIGHT != 0) data_q <= {shift_in, data_q[WIDTH-1:1]};
            else                  data_q <= {data_q[WIDTH-2:0], shift_in};
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Deserializer: assembles serial bits into WIDTH-bit words on a valid/ready output,
// buffering one held output word plus one completed word in the assembly register.
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int SHIFT_RIGHT = 0,
    localparam int CNT_W      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_count
);

    s2p_state_t       state_q;
    logic [CNT_W-1:0] bit_count_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] asm_q;
    logic [WIDTH-1:0] word_d;
    logic             acc;
    logic             drn;
    logic             last_bit;

    assign in_ready = (state_q == FILL);
    // clear outranks acc, so the assembly register must not see the bit either
    assign acc      = in_valid && in_ready && !clear;
    assign drn      = out_valid_q && out_ready;
    assign last_bit = (bit_count_q == CNT_W'(WIDTH - 1));

    // Word as it will look once the current bit has been shifted in
    assign word_d = (SHIFT_RIGHT != 0) ? {in_bit, asm_q[WIDTH-1:1]}
                                       : {asm_q[WIDTH-2:0], in_bit};

    shift_register #(
        .WIDTH      (WIDTH),
        .SHIFT_RIGHT(SHIFT_RIGHT)
    ) u_asm (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_data('0),
        .shift    (acc),
        .shift_in (in_bit),
        .data_out (asm_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            bit_count_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (drn) out_valid_q <= 1'b0;
            if (clear) begin
                state_q     <= FILL;
                bit_count_q <= '0;
            end else begin
                case (state_q)
                    FILL: begin
                        if (acc) begin
                            if (!last_bit) begin
                                bit_count_q <= bit_count_q + CNT_W'(1);
                            end else if (!out_valid_q || out_ready) begin
                                out_data_q  <= word_d;
                                out_valid_q <= 1'b1;
                                bit_count_q <= '0;
                            end else begin
                                state_q <= STALL;
                            end
                        end
                    end
                    STALL: begin
                        if (drn) begin
                            out_data_q  <= asm_q;
                            out_valid_q <= 1'b1;
                            bit_count_q <= '0;
                            state_q     <= FILL;
                        end
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign bit_count = bit_count_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomized + directed bench: MSB-first and LSB-first instances against a word-level model.
module tb_serial_to_parallel;

    localparam int W = 5;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst, clear, in_bit, in_valid, out_ready;
    logic          rdy0, rdy1, ov0, ov1;
    logic [W-1:0]  od0, od1;
    logic [CW-1:0] bc0, bc1;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state: accepted bits of the partial word, pending word, output slot
    int            part[$];
    logic          m_pend;
    logic [W-1:0]  m_pw0, m_pw1, m_ow0, m_ow1;
    logic          m_ov;

    always #5 clk = ~clk;

    serial_to_parallel #(.WIDTH(W), .SHIFT_RIGHT(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(rdy0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready),
        .bit_count(bc0));

    serial_to_parallel #(.WIDTH(W), .SHIFT_RIGHT(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready),
        .bit_count(bc1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // first bit of the stream lands in the MSB (msb_first) or LSB
    function automatic logic [W-1:0] pack(input bit msb_first);
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb_first) w[W-1-i] = part[i][0];
            else           w[i]     = part[i][0];
        end
        return w;
    endfunction

    task automatic model_step();
        logic nv;
        logic drn;
        drn = m_ov && out_ready;
        if (rst) begin
            part.delete(); m_pend = 0; m_ov = 0; m_ow0 = '0; m_ow1 = '0;
            return;
        end
        nv = drn ? 1'b0 : m_ov;
        if (clear) begin
            part.delete(); m_pend = 0;
        end else if (m_pend) begin
            if (drn) begin
                m_ow0 = m_pw0; m_ow1 = m_pw1; nv = 1; m_pend = 0;
            end
        end else if (in_valid) begin
            part.push_back(int'(in_bit));
            if (part.size() == W) begin
                if (!m_ov || out_ready) begin
                    m_ow0 = pack(1); m_ow1 = pack(0); nv = 1;
                end else begin
                    m_pw0 = pack(1); m_pw1 = pack(0); m_pend = 1;
                end
                part.delete();
            end
        end
        m_ov = nv;
    endtask

    task automatic compare_all();
        int exp_bc;
        exp_bc = m_pend ? W - 1 : part.size();
        chk("in_ready0", rdy0, !m_pend);
        chk("in_ready1", rdy1, !m_pend);
        chk("out_valid0", ov0, m_ov);
        chk("out_valid1", ov1, m_ov);
        chk("out_data0", od0, m_ow0);
        chk("out_data1", od1, m_ow1);
        chk("bit_count0", bc0, exp_bc);
        chk("bit_count1", bc1, exp_bc);
    endtask

    // one clock: drive, step model on the edge, compare on the falling edge
    task automatic cyc(input logic r, input logic c, input logic v, input logic b, input logic o);
        rst = r; clear = c; in_valid = v; in_bit = b; out_ready = o;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic [W-1:0] w, input logic o);
        for (int i = W - 1; i >= 0; i--) cyc(0, 0, 1, w[i], o);
    endtask

    initial begin
        rst = 1; clear = 0; in_valid = 0; in_bit = 0; out_ready = 0;
        part.delete(); m_pend = 0; m_ov = 0; m_ow0 = '0; m_ow1 = '0; m_pw0 = '0; m_pw1 = '0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        chk("rst_out_data", od0, 5'b0);
        chk("rst_in_ready", rdy0, 1'b1);

        // back-to-back words with the consumer always ready
        send(5'b10101, 1);
        chk("w0_data", od0, 5'b10101);
        chk("w0_valid", ov0, 1'b1);
        send(5'b11001, 1);
        chk("w1_data", od0, 5'b11001);
        cyc(0, 0, 0, 0, 1);

        // LSB-first instance
        send(5'b11000, 1);
        chk("lsb_data", od1, 5'b00011);
        cyc(0, 0, 0, 0, 1);

        // backpressure: two words buffered, then one drain
        send(5'b10101, 0);
        send(5'b01110, 0);
        chk("bp_data", od0, 5'b10101);
        chk("bp_ready", rdy0, 1'b0);
        cyc(0, 0, 0, 0, 1);
        chk("bp_data2", od0, 5'b01110);
        chk("bp_ready2", rdy0, 1'b1);
        chk("bp_count", bc0, 0);
        cyc(0, 0, 0, 0, 1);

        // idle gaps inside a word
        for (int i = W - 1; i >= 0; i--) begin
            logic [W-1:0] wv = 5'b11100;
            repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 1, 1);
            cyc(0, 0, 1, wv[i], 1);
        end
        chk("gap_data", od0, 5'b11100);

        // clear drops a partial word; clear with in_valid drops the bit
        cyc(0, 0, 1, 1, 1); cyc(0, 0, 1, 1, 1); cyc(0, 0, 1, 1, 1);
        cyc(0, 1, 0, 0, 1);
        send(5'b00001, 1);
        chk("clr_data", od0, 5'b00001);
        cyc(0, 1, 1, 1, 1);
        chk("clr_count", bc0, 0);

        // reset while stalled
        send(5'b10011, 0);
        send(5'b01100, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_stall_valid", ov0, 1'b0);
        chk("rst_stall_data", od0, 5'b0);
        chk("rst_stall_ready", rdy0, 1'b1);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
# serial_to_parallel

Deserializer that collects a serial bit stream into WIDTH-bit words and presents them on a valid/ready parallel output. It is the receive-side counterpart of `shift_register`: bits shifted out of a `shift_register` with the same WIDTH and SHIFT_RIGHT are reassembled into the original word. It sits at serial links feeding the LCMV datapath and absorbs output backpressure with one held word plus one assembling word.

## Interface
- WIDTH, 5: word width in bits; must be ≥ 2.
- SHIFT_RIGHT, 0: 0 = shift left, new bit enters LSB, first bit ends in MSB (MSB-first stream); 1 = shift right, new bit enters MSB, first bit ends in LSB (LSB-first stream).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  drops the partial word; the output register is unaffected.
- in_bit  in  1  serial data.
- in_valid  in  1  in_bit is valid this cycle.
- in_ready  out  1  bit accepted when in_valid && in_ready.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer takes the word when out_valid && out_ready.
- bit_count  out  CNT_W = $clog2(WIDTH)  bits accepted into the current partial word.

## Operation
- Reset values: state FILL, in_ready=1, out_valid=0, out_data=0, bit_count=0; the assembly register is 0.
- Accept: `acc = in_valid && in_ready`. Drain: `drn = out_valid && out_ready`.
- FILL (in_ready=1):
  - On acc with bit_count < WIDTH-1: shift in_bit into the assembly register and increment bit_count.
  - On acc with bit_count = WIDTH-1 (last bit):
    - If `!out_valid || out_ready`: out_data <= completed word (including this bit), out_valid <= 1, bit_count <= 0, stay in FILL.
    - Otherwise: the completed word stays in the assembly register and the state goes to STALL.
- STALL (in_ready=0, bit_count holds WIDTH-1): on drn, out_data <= assembly word, out_valid stays 1, bit_count <= 0, next state FILL.
- out_valid clears on drn only when no new word loads in the same cycle.
- clear (FILL or STALL): bit_count <= 0, state <= FILL, the partial or stalled word is discarded, and any acc that cycle is ignored. The out_data/out_valid handshake proceeds normally.
- rst has priority over clear, and clear has priority over acc.
- in_ready is a pure function of state. There is no combinational path from in_valid or out_ready to in_ready.

## Timing
- Latency: out_valid rises in the cycle after the last bit is accepted.
- Throughput: with out_ready held at 1, one word every WIDTH cycles, with no gap between words.
- Backpressure: the block holds one word in out_data and one complete word in assembly, then deasserts in_ready. in_ready reasserts in the cycle after drn.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Reset mid-word or mid-stall: all state returns to reset values at the next edge, and the pending output word is lost.

## Structure
- Package `s2p_pkg`: `typedef enum logic {FILL, STALL} s2p_state_t`.
- The assembly register is an instance of the existing `shift_register`:
  - WIDTH and SHIFT_RIGHT passed through.
  - load=0, load_data='0.
  - shift=acc, shift_in=in_bit.
  - rst tied to rst.
- Old bits shift out naturally, so no register clear is needed on clear.
- The counter, FSM and output register live in `serial_to_parallel`.

## Test plan
- WIDTH=5, SHIFT_RIGHT=0, out_ready=1, stream 1,0,1,0,1 on consecutive cycles → out_valid=1 for one cycle, one cycle after the 5th bit, out_data=5'b10101. Then stream 1,1,0,0,1 back-to-back → 5'b11001 five cycles later, with no in_ready drop.
- SHIFT_RIGHT=1, stream 1,1,0,0,0 → out_data=5'b00011.
- Backpressure: out_ready=0, send 10 bits (10101 then 01110) → out_valid=1, out_data=5'b10101, in_ready=0 after the 10th bit. Raise out_ready for one cycle → next cycle out_data=5'b01110, in_ready=1, bit_count=0.
- in_valid gaps: random idle cycles between the bits of 11100 → the same word is produced, and bit_count increments only on accepted cycles.
- clear after 3 bits (1,1,1), then stream 0,0,0,0,1 → out_data=5'b00001. clear asserted together with in_valid → that bit is dropped and bit_count=0.
- rst in STALL with out_valid=1 → next cycle out_valid=0, in_ready=1, bit_count=0, out_data=0.
